ps2_kbd_ctrl: RTL and testbench
===============================

# ps2_kbd_ctrl

Controller that sequences the PS/2 receiver's FIFO and turns its raw byte stream into keyboard events. It pops bytes using the receiver's `nextdata_n` handshake, and decodes the `E0` (extended) and `F0` (break) prefixes. It emits one make, break or repeat event per key code, and tracks held-key state and a press counter for the display logic. It sits between `ps2` and the seven-segment/top-level logic.

## Interface
- `PREFIX_TIMEOUT`, default 1_000_000: clk cycles a pending prefix survives without a following byte.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `rx_data` input 8: FIFO head byte from the receiver.
- `rx_ready` input 1: receiver FIFO non-empty.
- `rx_overflow` input 1: receiver overflow flag.
- `rx_nextdata_n` output 1: active-low pop strobe to the receiver.
- `evt_valid` output 1: one-cycle pulse, event fields valid.
- `evt_code` output 8: key code of the event (prefixes stripped).
- `evt_ext` output 1: event carried an `E0` prefix.
- `evt_make` output 1: 1 = press/repeat, 0 = release.
- `evt_repeat` output 1: typematic repeat of the currently held key.
- `key_held` output 1: a key is currently down.
- `held_code` output 8: code of the held key; `held_ext` is the ext flag of the held key.
- `held_ext` output 1: ext flag of the held key.
- `press_cnt` output 8: count of new (non-repeat) presses, mod 256.
- `err_sticky` output 1: set on overflow or an illegal byte; cleared only by rst.

## Operation
- Fetch FSM:
  - IDLE: when `rx_ready`=1, latch `rx_data` into `byte_q`, drive `rx_nextdata_n`=0, and go to POP.
  - POP: drive `rx_nextdata_n`=1, then go to GAP.
  - GAP: decode `byte_q`, then go to IDLE.
- The pop strobe is exactly one cycle low per byte. Bytes are never popped while `rx_ready`=0.
- Decode of `byte_q` in GAP:
  - `E0`: set `ext_pend`.
  - `F0`: set `brk_pend`.
  - `00` or `FF`: set `err_sticky` and clear both pending flags; no event.
  - `AA`, `FA`, `FE`: ignored; no event; pending flags unchanged.
  - Any other value is a key code; clear both pending flags afterwards.
- Key code with `brk_pend`=1:
  - Emit a release: `evt_make`=0, `evt_ext`=`ext_pend`.
  - If code and ext match the held key, clear `key_held`.
- Key code with `brk_pend`=0, matching the held key: emit with `evt_make`=1 and `evt_repeat`=1. Counter is unchanged.
- Key code with `brk_pend`=0, not matching the held key: emit with `evt_make`=1 and `evt_repeat`=0. Then:
  - increment `press_cnt` (wraps `FF`→`00`);
  - load `held_code` and `held_ext`;
  - set `key_held`.
- Prefix timeout:
  - A counter runs while either pending flag is set and the FSM is in IDLE with `rx_ready`=0.
  - When it reaches `PREFIX_TIMEOUT`-1, clear both pending flags; no event.
  - The counter resets to 0 on every byte fetched.
- `rx_overflow`=1 in any cycle sets `err_sticky`.

## Timing
- Reset values:
  - `rx_nextdata_n`=1.
  - `evt_valid`, `evt_code`, `evt_ext`, `evt_make`, `evt_repeat`=0.
  - `key_held`=0, `held_code`=`00`, `held_ext`=0.
  - `press_cnt`=0, `err_sticky`=0.
  - FSM in IDLE; pending flags and timeout counter cleared.
- Pop latency:
  - `rx_nextdata_n` falls in the cycle after the first `rx_ready`=1 sample.
  - `evt_valid` pulses 3 cycles after that `rx_ready` sample (registered in GAP).
- Throughput: one byte per 3 cycles.
  - With `rx_ready` held high, pops are spaced 3 cycles apart.
  - `rx_data` is not sampled during POP or GAP, so the FIFO pointer has settled before the next latch.
- Held-key state, `press_cnt` and `evt_*` update on the same edge as `evt_valid`.
- Event fields hold their values until the next event.
- `rst` mid-sequence (including during POP) returns to IDLE next edge with `rx_nextdata_n`=1; a half-received prefix is discarded.
- Simultaneous timeout expiry and `rx_ready` rising: the byte fetch wins and the counter resets. The pending flags are then used by that byte.

## Structure
- Shared package `ps2_pkg` holds:
  - byte constants `PS2_EXT`=`E0`, `PS2_BRK`=`F0`, `PS2_BAT`=`AA`, `PS2_ACK`=`FA`, `PS2_RESEND`=`FE`;
  - the fetch-state enum (IDLE, POP, GAP).
- One sub-module: `ps2_fetch_seq`, containing the 3-state pop FSM with `byte_q`/strobe output. `ps2_kbd_ctrl` keeps prefix decode, held-key tracking, counter and timeout.

## Test plan
- Feed `1C` with `rx_ready` high for one pop → one `rx_nextdata_n` low cycle; `evt_valid` with code `1C`, make=1, repeat=0, ext=0; `press_cnt`=1; `key_held`=1.
- Feed `1C,1C,F0,1C` → events: make, repeat (`press_cnt` stays 1), release (make=0); `key_held`=0 after the release.
- Feed `E0,75,E0,F0,75` back-to-back with `rx_ready` continuously high:
  - exactly 2 events, ext=1: make `75` then break `75`;
  - pops spaced 3 cycles.
- Feed `E0`, idle `PREFIX_TIMEOUT` cycles, then `75` → a single event `75` with ext=0.
- Feed `00`, then `AA`, then pulse `rx_overflow` → no events; `err_sticky`=1 after the `00` and it stays 1; the `AA` is popped.
- Assert `rst` during POP → next cycle `rx_nextdata_n`=1 and all outputs at reset values. Then `F0,2A` yields one release event, `press_cnt`=0. Separately, 257 distinct presses wrap `press_cnt` to 1.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
//==============================================================================
// Package     : ps2_pkg
// Description : Shared constants and types for the PS/2 keyboard controller.
//               Holds the protocol byte values the decoder recognises and the
//               fetch-sequencer state encoding.
// Revision    : 1.0 - initial release
//==============================================================================
package ps2_pkg;

    // Protocol byte values
    localparam logic [7:0] PS2_EXT    = 8'hE0;  // extended-key prefix
    localparam logic [7:0] PS2_BRK    = 8'hF0;  // break (release) prefix
    localparam logic [7:0] PS2_BAT    = 8'hAA;  // self-test passed
    localparam logic [7:0] PS2_ACK    = 8'hFA;  // command acknowledge
    localparam logic [7:0] PS2_RESEND = 8'hFE;  // resend request

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_POP  = 2'd1,
        FETCH_GAP  = 2'd2
    } fetch_state_t;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_kbd_ctrl_if.sv
`default_nettype none
//==============================================================================
// Interface   : ps2_kbd_ctrl_if
// Description : Bundles the receiver FIFO handshake and the keyboard event /
//               status outputs of ps2_kbd_ctrl.
//               master : the controller (pops the FIFO, produces events)
//               slave  : the receiver / display side
// Revision    : 1.0 - initial release
//==============================================================================
interface ps2_kbd_ctrl_if;

    // Receiver FIFO side
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_overflow;
    logic       rx_nextdata_n;

    // Event and status side
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_make;
    logic       evt_repeat;
    logic       key_held;
    logic [7:0] held_code;
    logic       held_ext;
    logic [7:0] press_cnt;
    logic       err_sticky;

    modport master (
        input  rx_data, rx_ready, rx_overflow,
        output rx_nextdata_n,
        output evt_valid, evt_code, evt_ext, evt_make, evt_repeat,
        output key_held, held_code, held_ext, press_cnt, err_sticky
    );

    modport slave (
        output rx_data, rx_ready, rx_overflow,
        input  rx_nextdata_n,
        input  evt_valid, evt_code, evt_ext, evt_make, evt_repeat,
        input  key_held, held_code, held_ext, press_cnt, err_sticky
    );

endinterface : ps2_kbd_ctrl_if
`default_nettype wire

// File: rtl/ps2_fetch_seq.sv
`default_nettype none
//==============================================================================
// Module      : ps2_fetch_seq
// Description : Three-state pop sequencer for the PS/2 receiver FIFO.
//               IDLE latches the FIFO head when it is non-empty, POP holds the
//               active-low pop strobe for one cycle, GAP lets the FIFO pointer
//               settle while the latched byte is decoded downstream.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_rx_ready         - receiver FIFO non-empty
//               i_rx_data          - receiver FIFO head byte
//               o_rx_nextdata_n    - registered active-low pop strobe
//               o_byte_q           - latched byte
//               o_fetch            - byte being latched this cycle
//               o_decode           - o_byte_q is to be decoded this cycle
//               o_idle             - sequencer is waiting for a byte
// Revision    : 1.0 - initial release
//==============================================================================
module ps2_fetch_seq
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx_ready,
    input  logic [7:0] i_rx_data,
    output logic       o_rx_nextdata_n,
    output logic [7:0] o_byte_q,
    output logic       o_fetch,
    output logic       o_decode,
    output logic       o_idle
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         r_nextdata_n;
    logic [7:0]   r_byte_q;
    logic         w_fetch;
    logic         w_decode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH_IDLE;
            r_nextdata_n <= 1'b1;
            r_byte_q     <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            // Strobe is registered so it is low for exactly the POP cycle.
            r_nextdata_n <= (w_state_nxt != FETCH_POP);
            if (w_fetch) begin
                r_byte_q <= i_rx_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        w_decode    = 1'b0;
        case (r_state)
            FETCH_IDLE: begin
                if (i_rx_ready) begin
                    w_fetch     = 1'b1;
                    w_state_nxt = FETCH_POP;
                end
            end
            FETCH_POP: begin
                w_state_nxt = FETCH_GAP;
            end
            FETCH_GAP: begin
                w_decode    = 1'b1;
                w_state_nxt = FETCH_IDLE;
            end
            default: begin
                w_state_nxt = FETCH_IDLE;
            end
        endcase
    end

    assign o_rx_nextdata_n = r_nextdata_n;
    assign o_byte_q        = r_byte_q;
    assign o_fetch         = w_fetch;
    assign o_decode        = w_decode;
    assign o_idle          = (r_state == FETCH_IDLE);

endmodule : ps2_fetch_seq
`default_nettype wire

// File: rtl/ps2_kbd_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : ps2_kbd_ctrl
// Description : PS/2 keyboard controller. Pops bytes from the receiver FIFO,
//               decodes the E0/F0 prefixes into make / break / repeat events,
//               tracks the held key, counts new presses and flags errors.
//               A pending prefix is dropped if no byte follows within
//               PREFIX_TIMEOUT idle cycles.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - ps2_kbd_ctrl_if.master (FIFO handshake + events)
// Revision    : 1.0 - initial release
//==============================================================================
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic           clk,
    input  logic           rst,
    ps2_kbd_ctrl_if.master bus
);

    localparam int                c_TMO_W    = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(PREFIX_TIMEOUT - 1);

    logic [7:0]         w_byte_q;
    logic               w_fetch;
    logic               w_decode;
    logic               w_idle;
    logic               w_match;
    logic               w_tmo_run;

    logic               r_ext_pend;
    logic               r_brk_pend;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_evt_valid;
    logic [7:0]         r_evt_code;
    logic               r_evt_ext;
    logic               r_evt_make;
    logic               r_evt_repeat;
    logic               r_key_held;
    logic [7:0]         r_held_code;
    logic               r_held_ext;
    logic [7:0]         r_press_cnt;
    logic               r_err_sticky;

    ps2_fetch_seq u_fetch (
        .clk             (clk),
        .rst             (rst),
        .i_rx_ready      (bus.rx_ready),
        .i_rx_data       (bus.rx_data),
        .o_rx_nextdata_n (bus.rx_nextdata_n),
        .o_byte_q        (w_byte_q),
        .o_fetch         (w_fetch),
        .o_decode        (w_decode),
        .o_idle          (w_idle)
    );

    // Same key means same code and same extended flag as the one held down.
    assign w_match   = r_key_held && (w_byte_q == r_held_code) && (r_ext_pend == r_held_ext);

    // Only starved idle time ages a prefix; a fetch in the same cycle wins.
    assign w_tmo_run = (r_ext_pend || r_brk_pend) && w_idle && !bus.rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
            r_tmo_cnt    <= '0;
            r_evt_valid  <= 1'b0;
            r_evt_code   <= 8'h00;
            r_evt_ext    <= 1'b0;
            r_evt_make   <= 1'b0;
            r_evt_repeat <= 1'b0;
            r_key_held   <= 1'b0;
            r_held_code  <= 8'h00;
            r_held_ext   <= 1'b0;
            r_press_cnt  <= 8'h00;
            r_err_sticky <= 1'b0;
        end else begin
            r_evt_valid <= 1'b0;

            if (bus.rx_overflow) begin
                r_err_sticky <= 1'b1;
            end

            // Prefix timeout (never overlaps decode: runs in IDLE only)
            if (w_fetch) begin
                r_tmo_cnt <= '0;
            end else if (w_tmo_run) begin
                if (r_tmo_cnt == c_TMO_LAST) begin
                    r_tmo_cnt  <= '0;
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                end
            end

            if (w_decode) begin
                case (w_byte_q)
                    PS2_EXT: r_ext_pend <= 1'b1;
                    PS2_BRK: r_brk_pend <= 1'b1;
                    8'h00, 8'hFF: begin
                        r_err_sticky <= 1'b1;
                        r_ext_pend   <= 1'b0;
                        r_brk_pend   <= 1'b0;
                    end
                    PS2_BAT, PS2_ACK, PS2_RESEND: begin
                        // Housekeeping replies: consumed, prefixes kept.
                    end
                    default: begin
                        r_evt_valid <= 1'b1;
                        r_evt_code  <= w_byte_q;
                        r_evt_ext   <= r_ext_pend;
                        r_ext_pend  <= 1'b0;
                        r_brk_pend  <= 1'b0;
                        if (r_brk_pend) begin
                            r_evt_make   <= 1'b0;
                            r_evt_repeat <= 1'b0;
                            if (w_match) begin
                                r_key_held <= 1'b0;
                            end
                        end else if (w_match) begin
                            r_evt_make   <= 1'b1;
                            r_evt_repeat <= 1'b1;
                        end else begin
                            r_evt_make   <= 1'b1;
                            r_evt_repeat <= 1'b0;
                            r_press_cnt  <= r_press_cnt + 8'd1;
                            r_held_code  <= w_byte_q;
                            r_held_ext   <= r_ext_pend;
                            r_key_held   <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.evt_valid  = r_evt_valid;
    assign bus.evt_code   = r_evt_code;
    assign bus.evt_ext    = r_evt_ext;
    assign bus.evt_make   = r_evt_make;
    assign bus.evt_repeat = r_evt_repeat;
    assign bus.key_held   = r_key_held;
    assign bus.held_code  = r_held_code;
    assign bus.held_ext   = r_held_ext;
    assign bus.press_cnt  = r_press_cnt;
    assign bus.err_sticky = r_err_sticky;

endmodule : ps2_kbd_ctrl
`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_ps2_kbd_ctrl
// Description : Self-checking bench for ps2_kbd_ctrl. A queue models the
//               receiver FIFO; expected events are queued as bytes are fed
//               and compared when the controller emits them.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ps2_kbd_ctrl;

    localparam int c_TMO = 16;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       make;
        logic       rpt;
    } evt_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   n_pops;
    int   last_pop;
    int   pops_before;
    logic [7:0] code_v;

    logic [7:0] rxq[$];
    evt_t       sb[$];
    int         pop_cyc_q[$];

    ps2_kbd_ctrl_if ifc ();

    ps2_kbd_ctrl #(
        .PREFIX_TIMEOUT (c_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rxq.push_back(b);
    endtask

    task automatic expect_evt(input logic [7:0] code, input logic ext, input logic make, input logic rpt);
        evt_t e;
        e.code = code; e.ext = ext; e.make = make; e.rpt = rpt;
        sb.push_back(e);
    endtask

    // Wait (bounded) until the FIFO model is empty, then let decode finish.
    task automatic drain();
        int n;
        n = 0;
        while ((rxq.size() != 0 || ifc.rx_ready) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_val("drain_timeout", 1, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic held, input logic [7:0] cnt, input logic err);
        check_val({tag, "_key_held"}, ifc.key_held, held);
        check_val({tag, "_press_cnt"}, ifc.press_cnt, cnt);
        check_val({tag, "_err"}, ifc.err_sticky, err);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Receiver FIFO model and event monitor, both on the falling edge.
    initial begin
        evt_t e;
        ifc.rx_ready = 1'b0;
        ifc.rx_data  = 8'h00;
        n_pops   = 0;
        last_pop = 0;
        forever begin
            @(negedge clk);
            if (!rst && ifc.evt_valid) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_evt", {24'h0, ifc.evt_code}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check_val("evt_code",   ifc.evt_code,   e.code);
                    check_val("evt_ext",    ifc.evt_ext,    e.ext);
                    check_val("evt_make",   ifc.evt_make,   e.make);
                    check_val("evt_repeat", ifc.evt_repeat, e.rpt);
                    check_val("evt_latency", cyc - last_pop, 2);
                end
            end
            if (!ifc.rx_nextdata_n) begin
                check_val("pop_when_ready", (rxq.size() != 0), 1);
                if (rxq.size() != 0) void'(rxq.pop_front());
                n_pops++;
                last_pop = cyc;
                pop_cyc_q.push_back(cyc);
            end
            ifc.rx_ready = (rxq.size() != 0);
            ifc.rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        ifc.rx_overflow = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state (checked while reset is still asserted and after release)
        check_val("rst_nextdata_n", ifc.rx_nextdata_n, 1);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_evt_valid",  ifc.evt_valid, 0);
        check_val("rst_evt_code",   ifc.evt_code, 0);
        check_val("rst_evt_fields", {ifc.evt_ext, ifc.evt_make, ifc.evt_repeat}, 0);
        check_val("rst_held",       {ifc.held_ext, ifc.held_code}, 0);
        check_state("rst", 1'b0, 8'd0, 1'b0);

        // Single press
        pops_before = n_pops;
        send(8'h1C); expect_evt(8'h1C, 1'b0, 1'b1, 1'b0);
        drain();
        check_val("single_pops", n_pops - pops_before, 1);
        check_state("single", 1'b1, 8'd1, 1'b0);
        check_val("single_held_code", ifc.held_code, 8'h1C);
        check_val("evt_fields_hold", ifc.evt_code, 8'h1C);

        // Repeat, then release
        send(8'h1C); expect_evt(8'h1C, 1'b0, 1'b1, 1'b1);
        send(8'hF0); send(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0, 1'b0);
        drain();
        check_state("rep_rel", 1'b0, 8'd1, 1'b0);

        // Extended make and break back-to-back; pops 3 cycles apart
        pop_cyc_q.delete();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        expect_evt(8'h75, 1'b1, 1'b1, 1'b0);
        expect_evt(8'h75, 1'b1, 1'b0, 1'b0);
        drain();
        check_val("b2b_pops", pop_cyc_q.size(), 5);
        for (int i = 1; i < pop_cyc_q.size(); i++)
            check_val("b2b_spacing", pop_cyc_q[i] - pop_cyc_q[i-1], 3);
        check_state("b2b", 1'b0, 8'd2, 1'b0);

        // Prefix timeout: E0 expires, 75 arrives as a plain make
        send(8'hE0);
        drain();
        repeat (c_TMO + 4) @(negedge clk);
        send(8'h75); expect_evt(8'h75, 1'b0, 1'b1, 1'b0);
        drain();
        check_state("tmo", 1'b1, 8'd3, 1'b0);
        check_val("tmo_held_ext", ifc.held_ext, 0);

        // Short idle keeps the prefix; E0 75 release does not match held 75/ext0
        send(8'hE0);
        drain();
        repeat (4) @(negedge clk);
        send(8'hF0); send(8'h75); expect_evt(8'h75, 1'b1, 1'b0, 1'b0);
        drain();
        check_state("short", 1'b1, 8'd3, 1'b0);
        send(8'hF0); send(8'h75); expect_evt(8'h75, 1'b0, 1'b0, 1'b0);
        drain();
        check_state("rel75", 1'b0, 8'd3, 1'b0);

        // Illegal and housekeeping bytes
        pops_before = n_pops;
        send(8'h00);
        drain();
        check_state("illegal", 1'b0, 8'd3, 1'b1);
        send(8'hAA);
        drain();
        check_val("aa_popped", n_pops - pops_before, 2);
        check_val("aa_err_stays", ifc.err_sticky, 1);
        send(8'hE0); send(8'h00); send(8'h2B); expect_evt(8'h2B, 1'b0, 1'b1, 1'b0);
        send(8'hE0); send(8'hFA); send(8'h1D); expect_evt(8'h1D, 1'b1, 1'b1, 1'b0);
        drain();
        check_state("ign", 1'b1, 8'd5, 1'b1);
        check_val("ign_held", {ifc.held_ext, ifc.held_code}, {1'b1, 8'h1D});

        // Reset during POP discards the pending E0
        send(8'hE0);
        drain();
        send(8'h3C);
        n = 0;
        while (ifc.rx_nextdata_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("pop_wait_timeout", 1, 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_nextdata_n", ifc.rx_nextdata_n, 1);
        check_val("midrst_evt", {ifc.evt_valid, ifc.evt_code, ifc.evt_ext, ifc.evt_make, ifc.evt_repeat}, 0);
        check_val("midrst_held", {ifc.held_ext, ifc.held_code}, 0);
        check_state("midrst", 1'b0, 8'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        send(8'hF0); send(8'h2A); expect_evt(8'h2A, 1'b0, 1'b0, 1'b0);
        drain();
        check_state("post_rst", 1'b0, 8'd0, 1'b0);

        // Overflow sets the sticky error
        ifc.rx_overflow = 1'b1;
        @(negedge clk);
        ifc.rx_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check_val("overflow_err", ifc.err_sticky, 1);

        // 257 new presses wrap the counter to 1
        do_reset();
        for (int i = 0; i < 257; i++) begin
            code_v = 8'(1 + (i % 100));
            send(code_v);
            expect_evt(code_v, 1'b0, 1'b1, 1'b0);
        end
        drain();
        check_state("wrap", 1'b1, 8'd1, 1'b0);
        check_val("wrap_held_code", ifc.held_code, 8'(1 + (256 % 100)));

        check_val("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ps2_kbd_ctrl
`default_nettype wire
